uart_rx: RTL and testbench

- UART receiver; the downstream counterpart of uart_tx. It deserialises the tx_sig line (8N1 framing, LSB first) into parallel bytes.
- Bytes are presented to the host through a one-entry valid/ready output register.
- Sits on the FPGA receive path, either in loopback benches with uart_tx or facing an external UART.
- Flags framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with 2-flop input synchroniser, one-entry
//           valid/ready output register, framing-error and overrun pulses.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data_to_host,
    output logic                  valid_to_host,
    input  logic                  ready_from_host,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE  = PULSE_WIDTH / 2;
    localparam int c_cnt_w     = $clog2(PULSE_WIDTH);
    localparam int c_idx_w     = $clog2(DATA_WIDTH + 1);

    localparam logic [c_cnt_w-1:0] c_half_last  = c_cnt_w'(HALF_PULSE - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_bit_last   = c_idx_w'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [c_cnt_w-1:0]    r_clk_cnt;
    logic [c_idx_w-1:0]    r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  w_rx_s;

    // Synchroniser flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_sig;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_valid && ready_from_host) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_clk_cnt == c_half_last) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_clk_cnt == c_pulse_last) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_idx == c_bit_last) begin
                            r_bit_idx <= '0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_clk_cnt == c_pulse_last) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            // A same-edge handshake frees the slot for the new byte.
                            if (!r_valid || ready_from_host) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    r_clk_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    assign data_to_host  = r_data;
    assign valid_to_host = r_valid;
    assign frame_err     = r_frame_err;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Scoreboard bench for uart_rx at 100 clocks per bit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int P   = 100;
    localparam int H   = P / 2;
    localparam int LAT = 2 + H + 9 * P + 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_sig = 1'b1;
    logic [7:0] data_to_host;
    logic       valid_to_host;
    logic       ready_from_host = 1'b1;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (1_000_000),
        .CLK_FREQ  (100_000_000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rx_sig         (rx_sig),
        .data_to_host   (data_to_host),
        .valid_to_host  (valid_to_host),
        .ready_from_host(ready_from_host),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid_to_host && !prev_valid) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) chk("flags_exclusive", 1, 0);
            if (valid_to_host && ready_from_host) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", int'(data_to_host), -1);
                end else begin
                    chk("transfer_data", int'(data_to_host), int'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = valid_to_host;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_sig = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            rx_sig = b[i];
            tick(P);
        end
        rx_sig = stop;
        tick(P);
        rx_sig = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    initial begin
        int fe0, ov0, r0, c0;

        // Reset values
        tick(5);
        chk("reset_data", int'(data_to_host), 0);
        chk("reset_valid", int'(valid_to_host), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        chk("reset_overrun", int'(overrun), 0);
        rstn = 1'b1;
        tick(5);

        // Single byte with latency measurement
        exp_q.push_back(8'hA5);
        c0 = cyc;
        r0 = rise_cnt;
        send_frame(8'hA5, 1'b1);
        tick(P);
        chk("single_rise_count", rise_cnt - r0, 1);
        chk("single_latency_in_window",
            int'((rise_cyc - c0) >= LAT - 1 && (rise_cyc - c0) <= LAT + 1), 1);
        chk("single_no_flags", fe_cnt + ov_cnt, 0);

        // Reset mid-frame: no partial byte delivered
        r0 = rise_cnt;
        rx_sig = 1'b0;
        tick(P);
        for (int i = 0; i < 4; i++) begin
            rx_sig = 1'(i % 2);
            tick(P);
        end
        rstn = 1'b0;
        rx_sig = 1'b1;
        tick(3);
        chk("midreset_valid", int'(valid_to_host), 0);
        chk("midreset_data", int'(data_to_host), 0);
        rstn = 1'b1;
        tick(12 * P);
        chk("midreset_no_delivery", rise_cnt - r0, 0);

        // Back-to-back frames
        send_ok(8'hC4);
        send_ok(8'hB5);
        send_ok(8'h9A);
        tick(2 * P);
        chk("b2b_drained", exp_q.size(), 0);

        // Glitch rejection (pulse shorter than half a bit)
        r0 = rise_cnt;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_sig = 1'b0;
        tick(20);
        rx_sig = 1'b1;
        tick(3 * P);
        chk("glitch_no_valid", rise_cnt - r0, 0);
        chk("glitch_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_ok(8'h3C);
        tick(2 * P);
        chk("glitch_next_frame", exp_q.size(), 0);

        // Framing error followed by break
        r0 = rise_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        rx_sig = 1'b0;
        tick(3 * P);
        rx_sig = 1'b1;
        tick(2 * P);
        chk("break_frame_err_once", fe_cnt - fe0, 1);
        chk("break_no_valid", rise_cnt - r0, 0);
        send_ok(8'h5A);
        tick(2 * P);
        chk("break_next_frame", exp_q.size(), 0);

        // Overrun with host stalled
        ready_from_host = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(P);
        chk("overrun_data_held", int'(data_to_host), 'h11);
        chk("overrun_valid_held", int'(valid_to_host), 1);
        chk("overrun_pulse_once", ov_cnt - ov0, 1);
        ready_from_host = 1'b1;
        tick(3);
        chk("overrun_drained", exp_q.size(), 0);

        // Same-cycle accept on the stop-sample edge of the second byte
        ready_from_host = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(LAT - 1);
                ready_from_host = 1'b1;
                tick(1);
                ready_from_host = 1'b0;
            end
        join
        tick(P);
        chk("same_cycle_no_overrun", ov_cnt - ov0, 0);
        chk("same_cycle_next_data", int'(data_to_host), 'h22);
        ready_from_host = 1'b1;
        tick(3);
        chk("same_cycle_drained", exp_q.size(), 0);

        // Loopback-style stream with one idle bit between frames
        send_ok(8'hA5);
        tick(P);
        send_ok(8'hC4);
        tick(P);
        send_ok(8'hB5);
        tick(2 * P);
        chk("loopback_drained", exp_q.size(), 0);
        chk("total_frame_errs", fe_cnt, 1);
        chk("total_overruns", ov_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles, expected completion", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
